// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - in-order branch tracking FIFO between fetch, predictor and execute
// Captures predictor outputs, trains the predictor on resolve, and flushes younger branches on a mispredict.
module branch_resolver #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_valid,
    output logic                       fetch_ready,
    output logic                       request,
    input  logic                       prediction,
    output logic                       pred_valid,
    output logic                       pred_taken,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    output logic                       result,
    output logic                       taken,
    output logic                       mispredict,
    output logic                       mispredict_taken,
    output logic                       resolve_error,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           branch_count,
    output logic [CNT_W-1:0]           mispredict_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [OW-1:0]    count;
    logic             pend;
    logic             empty;
    logic             head;
    logic             mis_now;

    assign empty       = (count == '0);
    assign head        = mem[rd_ptr];
    assign result      = resolve_valid && !empty;
    assign taken       = result && resolve_taken;
    assign mis_now     = result && (resolve_taken != head);
    assign occupancy   = count + OW'(pend);
    // A pop in this cycle does not count toward free space for fetch.
    assign fetch_ready = (occupancy < OW'(DEPTH)) && !mis_now;
    assign request     = fetch_valid && fetch_ready;
    // A pending capture that is about to be flushed is never reported.
    assign pred_valid  = pend && !mis_now;
    assign pred_taken  = pred_valid && prediction;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem              <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            pend             <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
            mispredict       <= 1'b0;
            mispredict_taken <= 1'b0;
            resolve_error    <= 1'b0;
        end else begin
            mispredict       <= mis_now;
            mispredict_taken <= mis_now && resolve_taken;
            resolve_error    <= resolve_valid && empty;
            if (result) begin
                branch_count <= branch_count + 1'b1;
            end
            if (mis_now) begin
                mispredict_count <= mispredict_count + 1'b1;
                wr_ptr           <= '0;
                rd_ptr           <= '0;
                count            <= '0;
                pend             <= 1'b0;
            end else begin
                pend <= request;
                if (pend) begin
                    mem[wr_ptr] <= prediction;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (result) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + OW'(pend) - OW'(result);
            end
        end
    end
endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed self-checking bench for branch_resolver
module tb_branch_resolver;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid, fetch_ready, request, prediction, pred_valid, pred_taken;
    logic        resolve_valid, resolve_taken, result, taken;
    logic        mispredict, mispredict_taken, resolve_error;
    logic [3:0]  occupancy;
    logic [15:0] branch_count, mispredict_count;
    int          checks = 0;
    int          errors = 0;
    int          nreq;

    branch_resolver #(.DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .request(request),
        .prediction(prediction), .pred_valid(pred_valid), .pred_taken(pred_taken),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .result(result), .taken(taken),
        .mispredict(mispredict), .mispredict_taken(mispredict_taken),
        .resolve_error(resolve_error), .occupancy(occupancy),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic cyc(input logic fv, input logic pr, input logic rv, input logic rt);
        @(negedge clk);
        fetch_valid   = fv;
        prediction    = pr;
        resolve_valid = rv;
        resolve_taken = rt;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        fetch_valid = 0; prediction = 0; resolve_valid = 0; resolve_taken = 0;
        #1;
        chk("rst_occupancy", occupancy, 0);
        chk("rst_mispredict", mispredict, 0);
        chk("rst_resolve_error", resolve_error, 0);
        chk("rst_branch_count", branch_count, 0);
        chk("rst_fetch_ready", fetch_ready, 1);
        chk("rst_pred_valid", pred_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three fetches, predictor answers 1,0,1 one cycle after each request
        cyc(1, 0, 0, 0); chk("f1_request", request, 1); chk("f1_pred_valid", pred_valid, 0);
        cyc(1, 1, 0, 0); chk("f2_request", request, 1); chk("f2_pv", pred_valid, 1); chk("f2_pt", pred_taken, 1);
        cyc(1, 0, 0, 0); chk("f3_request", request, 1); chk("f3_pv", pred_valid, 1); chk("f3_pt", pred_taken, 0);
        cyc(0, 1, 0, 0); chk("f4_request", request, 0); chk("f4_pv", pred_valid, 1); chk("f4_pt", pred_taken, 1);
        cyc(0, 0, 0, 0); chk("f5_pv", pred_valid, 0); chk("f5_occupancy", occupancy, 3);

        // Correct resolves 1,0,1
        cyc(0, 0, 1, 1); chk("r1_result", result, 1); chk("r1_taken", taken, 1);
        cyc(0, 0, 1, 0); chk("r2_result", result, 1); chk("r2_taken", taken, 0); chk("r2_mis", mispredict, 0);
        cyc(0, 0, 1, 1); chk("r3_result", result, 1); chk("r3_taken", taken, 1); chk("r3_mis", mispredict, 0);
        cyc(0, 0, 0, 0); chk("r4_mis", mispredict, 0); chk("r4_branch_count", branch_count, 3);
        chk("r4_occupancy", occupancy, 0);

        // Four stored plus one pending, head mispredicted
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 1, 0);
        chk("m_occ_before", occupancy, 5); chk("m_result", result, 1); chk("m_taken", taken, 0);
        chk("m_fetch_ready", fetch_ready, 0); chk("m_pv_pending", pred_valid, 0);
        cyc(0, 0, 0, 0);
        chk("m_mispredict", mispredict, 1); chk("m_mis_taken", mispredict_taken, 0);
        chk("m_occupancy", occupancy, 0); chk("m_pred_valid", pred_valid, 0);
        chk("m_mis_count", mispredict_count, 1); chk("m_branch_count", branch_count, 4);
        cyc(0, 0, 0, 0); chk("m_pulse_end", mispredict, 0);

        // Fetch held for 12 cycles fills exactly DEPTH entries
        nreq = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1, 1, 0, 0);
            if (request) nreq++;
        end
        chk("full_requests", nreq, 8);
        cyc(0, 1, 0, 0); chk("full_ready", fetch_ready, 0); chk("full_occupancy", occupancy, 8);
        cyc(1, 1, 1, 1); chk("full_pop_ready", fetch_ready, 0); chk("full_pop_request", request, 0);
        cyc(0, 0, 0, 0); chk("full_after_ready", fetch_ready, 1); chk("full_after_occ", occupancy, 7);
        chk("full_after_bc", branch_count, 5);
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 0); chk("drain_occ", occupancy, 0); chk("drain_bc", branch_count, 12);
        chk("drain_mis", mispredict_count, 1);

        // Resolve on empty, then resolve with only a pending capture
        cyc(0, 0, 1, 1); chk("e_result", result, 0); chk("e_taken", taken, 0);
        cyc(0, 0, 0, 0); chk("e_error", resolve_error, 1); chk("e_bc", branch_count, 12);
        chk("e_mis", mispredict, 0);
        cyc(0, 0, 0, 0); chk("e_error_end", resolve_error, 0);
        cyc(1, 0, 0, 0); chk("p_request", request, 1);
        cyc(0, 1, 1, 0); chk("p_result", result, 0); chk("p_pv", pred_valid, 1);
        cyc(0, 0, 0, 0); chk("p_error", resolve_error, 1); chk("p_bc", branch_count, 12);
        chk("p_mc", mispredict_count, 1); chk("p_occ", occupancy, 1);
        cyc(0, 0, 1, 1); chk("p_drain_result", result, 1);
        cyc(0, 0, 0, 0); chk("p_drain_occ", occupancy, 0); chk("p_drain_bc", branch_count, 13);

        // Five entries, mispredict in flight, async reset mid-cycle
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 1); chk("a_occ", occupancy, 5); chk("a_result", result, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("a_rst_occ", occupancy, 0); chk("a_rst_result", result, 0);
        chk("a_rst_bc", branch_count, 0); chk("a_rst_mc", mispredict_count, 0);
        chk("a_rst_pv", pred_valid, 0);
        @(posedge clk); #1;
        chk("a_rst_mis", mispredict, 0); chk("a_rst_err", resolve_error, 0);
        chk("a_rst_occ2", occupancy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
